// File: rtl/transform_scheduler_if.sv
// Command and transformed-triangle stream channels of the transform scheduler.
// The slave modport is the scheduler's own view; master is the surrounding front end and Transform.
interface transform_scheduler_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned TRI_W  = 32,
    parameter int unsigned XF_W   = 32
);
    logic [ADDR_W-1:0]     cmd_s_base;
    logic [ADDR_W-1:0]     cmd_s_count;
    logic [XF_W-1:0]       cmd_s_transform;
    logic                  cmd_s_model_last;
    logic                  cmd_s_valid;
    logic                  cmd_s_ready;

    logic [TRI_W+XF_W-1:0] triangle_tf_m_data;
    logic [1:0]            triangle_tf_m_metadata;  // {triangle_last, model_last}
    logic                  triangle_tf_m_valid;
    logic                  triangle_tf_m_ready;

    modport slave (
        input  cmd_s_base, cmd_s_count, cmd_s_transform, cmd_s_model_last, cmd_s_valid,
        output cmd_s_ready,
        output triangle_tf_m_data, triangle_tf_m_metadata, triangle_tf_m_valid,
        input  triangle_tf_m_ready
    );

    modport master (
        output cmd_s_base, cmd_s_count, cmd_s_transform, cmd_s_model_last, cmd_s_valid,
        input  cmd_s_ready,
        input  triangle_tf_m_data, triangle_tf_m_metadata, triangle_tf_m_valid,
        output triangle_tf_m_ready
    );
endinterface

// File: rtl/transform_scheduler.sv
// Fetches one model's triangles from the triangle RAM and streams them, paired with the
// model transform, to Transform; read issue is credit-limited by the FWFT read-data FIFO.
module transform_scheduler #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TRI_W      = 32,
    parameter int unsigned XF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    transform_scheduler_if.slave bus,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [TRI_W-1:0]  mem_rd_data,
    output logic              busy,
    output logic              err_empty_cmd
);
    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + MEM_LAT + 1);
    localparam logic [PtrW-1:0] PtrMax = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] Depth  = CntW'(FIFO_DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d, count_q, count_d, idx_q, idx_d;
    logic [XF_W-1:0]     xf_q, xf_d;
    logic                model_last_q, model_last_d;
    logic [MEM_LAT-1:0]  tag_v_q, tag_v_d, tag_l_q, tag_l_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d, outst_q, outst_d;
    logic                err_q, err_d;
    logic [TRI_W:0]      fifo_q [FIFO_DEPTH];

    logic                accept, issue, push, pop, is_last, fifo_empty;
    logic [TRI_W:0]      head;

    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_ptr_q];
    assign push       = tag_v_q[MEM_LAT-1];
    assign pop        = bus.triangle_tf_m_valid && bus.triangle_tf_m_ready;
    assign is_last    = (idx_q == count_q - ADDR_W'(1));

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        count_d         = count_q;
        idx_d           = idx_q;
        xf_d            = xf_q;
        model_last_d    = model_last_q;
        err_d           = 1'b0;
        issue           = 1'b0;
        bus.cmd_s_ready = (state_q == StIdle) && !rst;
        accept          = bus.cmd_s_ready && bus.cmd_s_valid;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.cmd_s_count == '0) begin
                        err_d = 1'b1;
                    end else begin
                        base_d       = bus.cmd_s_base;
                        count_d      = bus.cmd_s_count;
                        xf_d         = bus.cmd_s_transform;
                        model_last_d = bus.cmd_s_model_last;
                        idx_d        = '0;
                        state_d      = StFetch;
                    end
                end
            end
            StFetch: begin
                // A beat popped this cycle frees its credit immediately.
                issue = !rst && ((outst_q + cnt_q - CntW'(pop)) < Depth);
                if (issue) begin
                    idx_d = idx_q + ADDR_W'(1);
                    if (is_last) state_d = StDrain;
                end
            end
            StDrain: begin
                if (outst_q == '0 && (cnt_q - CntW'(pop)) == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tag_v_d[0] = issue;
        tag_l_d[0] = issue && is_last;
        for (int i = 1; i < MEM_LAT; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_l_d[i] = tag_l_q[i-1];
        end
        outst_d  = outst_q + CntW'(issue) - CntW'(push);
        cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrW'(1);
    end

    always_comb begin
        bus.triangle_tf_m_valid    = !fifo_empty && !rst;
        bus.triangle_tf_m_data     = '0;
        bus.triangle_tf_m_metadata = '0;
        if (bus.triangle_tf_m_valid) begin
            bus.triangle_tf_m_data     = {head[TRI_W:1], xf_q};
            bus.triangle_tf_m_metadata = {head[0], head[0] && model_last_q};
        end
    end

    assign mem_rd_en     = issue;
    assign mem_rd_addr   = base_q + idx_q;
    assign busy          = (state_q != StIdle);
    assign err_empty_cmd = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            base_q       <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            xf_q         <= '0;
            model_last_q <= 1'b0;
            tag_v_q      <= '0;
            tag_l_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            outst_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            xf_q         <= xf_d;
            model_last_q <= model_last_d;
            tag_v_q      <= tag_v_d;
            tag_l_q      <= tag_l_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            outst_q      <= outst_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) fifo_q[wr_ptr_q] <= {mem_rd_data, tag_l_q[MEM_LAT-1]};
        if (!rst) assert (!(push && !pop && cnt_q == Depth));
    end
endmodule

// File: tb/tb_transform_scheduler.sv
// Directed bench for transform_scheduler: queued expectations for reads and output beats,
// checked by independent monitors on the falling edge.
module tb_transform_scheduler;
    localparam int unsigned ADDR_W = 12, MEM_LAT = 2, FIFO_DEPTH = 4, TRI_W = 32, XF_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    transform_scheduler_if #(.ADDR_W(ADDR_W), .TRI_W(TRI_W), .XF_W(XF_W)) bus ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [TRI_W-1:0]  mem_rd_data;
    logic              busy, err_empty_cmd;

    transform_scheduler #(
        .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TRI_W(TRI_W), .XF_W(XF_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .busy(busy), .err_empty_cmd(err_empty_cmd)
    );

    function automatic logic [TRI_W-1:0] tri_of(input logic [ADDR_W-1:0] a);
        return {20'hC0DE0, a};
    endfunction

    // Triangle RAM: data for an address read in cycle k appears in cycle k+MEM_LAT.
    logic [ADDR_W-1:0] a_pipe [MEM_LAT];
    always @(posedge clk) begin
        a_pipe[0] <= mem_rd_addr;
        for (int i = 1; i < MEM_LAT; i++) a_pipe[i] <= a_pipe[i-1];
    end
    assign mem_rd_data = tri_of(a_pipe[MEM_LAT-1]);

    int total = 0;
    int bad   = 0;
    logic [ADDR_W-1:0]      exp_addrs [$];
    logic [TRI_W+XF_W+1:0]  exp_beats [$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read-address order and credit bound.
    initial begin
        int inflight = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                inflight = 0;
            end else begin
                if (mem_rd_en) inflight++;
                if (bus.triangle_tf_m_valid && bus.triangle_tf_m_ready) inflight--;
                if (mem_rd_en) begin
                    check("credit_bound", 72'(inflight > FIFO_DEPTH), 72'(0));
                    if (exp_addrs.size() == 0) check("unexpected_read", 72'(mem_rd_addr), 72'hFFF_FFFF);
                    else check("read_addr", 72'(mem_rd_addr), 72'(exp_addrs.pop_front()));
                end
            end
        end
    end

    // Output beats and stability under backpressure.
    initial begin
        logic [TRI_W+XF_W+1:0] cur, prev;
        logic stalled = 1'b0;
        forever begin
            @(negedge clk);
            cur = {bus.triangle_tf_m_data, bus.triangle_tf_m_metadata};
            if (stalled && bus.triangle_tf_m_valid) check("stall_stable", 72'(cur), 72'(prev));
            if (bus.triangle_tf_m_valid && bus.triangle_tf_m_ready) begin
                if (exp_beats.size() == 0) check("unexpected_beat", 72'(cur), 72'hFF_FFFF_FFFF_FFFF_FFFF);
                else check("beat", 72'(cur), 72'(exp_beats.pop_front()));
            end
            stalled = bus.triangle_tf_m_valid && !bus.triangle_tf_m_ready;
            prev    = cur;
        end
    end

    task automatic send_cmd(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] count,
                            input logic [XF_W-1:0] xf, input logic ml);
        int   n   = 0;
        logic acc = 1'b0;
        for (int i = 0; i < int'(count); i++) begin
            logic [ADDR_W-1:0] a;
            logic              l;
            a = base + ADDR_W'(i);
            l = (i == int'(count) - 1);
            exp_addrs.push_back(a);
            exp_beats.push_back({tri_of(a), xf, l, l && ml});
        end
        bus.cmd_s_base       = base;
        bus.cmd_s_count      = count;
        bus.cmd_s_transform  = xf;
        bus.cmd_s_model_last = ml;
        bus.cmd_s_valid      = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.cmd_s_ready;
            step();
            n++;
        end
        bus.cmd_s_valid = 1'b0;
        if (!acc) check("cmd_accept_timeout", 72'(0), 72'(1));
    endtask

    task automatic wait_done(input bit toggle);
        int n = 0;
        while ((busy || exp_beats.size() != 0) && n < 300) begin
            bus.triangle_tf_m_ready = toggle ? (n % 4 == 0) : 1'b1;
            step();
            n++;
        end
        bus.triangle_tf_m_ready = 1'b1;
        if (n >= 300) check("done_timeout", 72'(0), 72'(1));
    endtask

    initial begin
        int n;
        bus.cmd_s_base = '0; bus.cmd_s_count = '0; bus.cmd_s_transform = '0;
        bus.cmd_s_model_last = 1'b0; bus.cmd_s_valid = 1'b0; bus.triangle_tf_m_ready = 1'b1;
        repeat (3) step();
        check("ready_in_reset", 72'(bus.cmd_s_ready), 72'(0));
        rst = 1'b0;
        #1;
        check("rst_ready", 72'(bus.cmd_s_ready), 72'(1));
        check("rst_rd_en", 72'(mem_rd_en), 72'(0));
        check("rst_rd_addr", 72'(mem_rd_addr), 72'(0));
        check("rst_valid", 72'(bus.triangle_tf_m_valid), 72'(0));
        check("rst_data_meta", 72'({bus.triangle_tf_m_data, bus.triangle_tf_m_metadata}), 72'(0));
        check("rst_busy_err", 72'({busy, err_empty_cmd}), 72'(0));

        // Basic count=3, ready high: latency and back-to-back beats.
        send_cmd(12'h010, 12'd3, 32'h1111_AAAA, 1'b1);
        check("rd_en_after_accept", 72'(mem_rd_en), 72'(1));
        check("ready_low_in_fetch", 72'(bus.cmd_s_ready), 72'(0));
        n = 0;
        while (!bus.triangle_tf_m_valid && n < 20) begin step(); n++; end
        check("first_valid_latency", 72'(n), 72'(3));
        for (int k = 0; k < 3; k++) begin
            check("beat_consecutive", 72'(bus.triangle_tf_m_valid), 72'(1));
            step();
        end
        check("busy_after_last", 72'(busy), 72'(0));

        // Same command under 1-on/3-off backpressure.
        send_cmd(12'h010, 12'd3, 32'h2222_BBBB, 1'b1);
        wait_done(1'b1);

        // Address wrap.
        send_cmd(12'hFFE, 12'd4, 32'h3333_CCCC, 1'b0);
        wait_done(1'b0);

        // Empty command.
        send_cmd(12'h123, 12'd0, 32'h4444_DDDD, 1'b1);
        check("err_pulse", 72'(err_empty_cmd), 72'(1));
        check("empty_ready", 72'(bus.cmd_s_ready), 72'(1));
        check("empty_no_read", 72'(mem_rd_en), 72'(0));
        step();
        check("err_single", 72'(err_empty_cmd), 72'(0));
        repeat (6) step();

        // Two commands with valid held: B only after A's last beat.
        send_cmd(12'h040, 12'd2, 32'h5555_0000, 1'b0);
        send_cmd(12'h080, 12'd1, 32'h6666_1111, 1'b1);
        check("b_after_a_last", 72'(exp_beats.size()), 72'(1));
        wait_done(1'b0);

        // Reset one cycle after the second read of a count=5 command.
        send_cmd(12'h100, 12'd5, 32'h7777_2222, 1'b1);
        step();
        check("second_read", 72'(mem_rd_en), 72'(1));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("post_rst_valid", 72'(bus.triangle_tf_m_valid), 72'(0));
        check("post_rst_busy", 72'(busy), 72'(0));
        check("post_rst_ready", 72'(bus.cmd_s_ready), 72'(1));
        check("reads_cut_short", 72'(exp_addrs.size()), 72'(3));
        repeat (6) step();
        check("no_beats_after_rst", 72'(exp_beats.size()), 72'(5));
        exp_addrs.delete();
        exp_beats.delete();
        send_cmd(12'h200, 12'd1, 32'h8888_3333, 1'b1);
        wait_done(1'b0);

        repeat (5) step();
        check("addrs_left", 72'(exp_addrs.size()), 72'(0));
        check("beats_left", 72'(exp_beats.size()), 72'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/transform_scheduler.md
Name: transform_scheduler

Overview:
- Sequences the shared Transform unit over whole models.
- Accepts one model command at a time: base address, triangle count, transform and a model_last flag.
- Fetches the model's triangles from the triangle RAM, pairs each with the latched transform, and streams triangle_tf_t beats with triangle_last/model_last metadata into Transform's slave port.
- Sits between the scene/command front end and Transform.

Parameters:
ADDR_W, 12, width of triangle RAM address and of triangle count
MEM_LAT, 2, fixed triangle RAM read latency in cycles (>=1)
FIFO_DEPTH, 4, read-data buffer depth; must be >= MEM_LAT+1 for 1 beat/cycle

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_s_base  in  ADDR_W  first triangle address of model
cmd_s_count  in  ADDR_W  number of triangles (0 = empty command)
cmd_s_transform  in  $bits(transform_t)  rotmat + position for model
cmd_s_model_last  in  1  command is final model of frame
cmd_s_valid  in  1  command valid
cmd_s_ready  out  1  command accepted when valid&&ready
mem_rd_en  out  1  triangle RAM read strobe
mem_rd_addr  out  ADDR_W  triangle RAM read address
mem_rd_data  in  $bits(triangle_t)  read data, valid MEM_LAT cycles after mem_rd_en
triangle_tf_m_data  out  $bits(triangle_tf_t)  {triangle, transform} to Transform
triangle_tf_m_metadata  out  $bits(triangle_tf_meta_t)  {triangle_last, model_last}
triangle_tf_m_valid  out  1  beat valid
triangle_tf_m_ready  in  1  Transform ready
busy  out  1  state != IDLE
err_empty_cmd  out  1  one-cycle pulse on acceptance of count==0 command

Behaviour:
- Reset values: cmd_s_ready=0 during rst, 1 the first cycle after; mem_rd_en=0, mem_rd_addr=0, triangle_tf_m_valid=0, data/metadata=0, busy=0, err_empty_cmd=0.
- FSM: IDLE, FETCH, DRAIN.
- IDLE: cmd_s_ready=1.
  - On accept with count!=0: latch base, count, transform, model_last; reset issue index and outstanding counters; go to FETCH.
  - On accept with count==0: pulse err_empty_cmd the next cycle; no beats produced; stay in IDLE.
- FETCH: each cycle, mem_rd_en=1 iff (outstanding reads + FIFO occupancy) < FIFO_DEPTH.
  - mem_rd_addr = base + index, modulo 2^ADDR_W (wraps silently).
  - index increments on each issued read.
  - After issuing read count-1, go to DRAIN.
- DRAIN: no reads; go to IDLE the cycle after the FIFO is empty and outstanding==0, with the final beat handshaken.
- cmd_s_ready=0 in FETCH/DRAIN; commands never overlap, so model_last ordering is preserved.
- Read tracking: a MEM_LAT-deep valid/last shift pipeline tags each read. Tag last = (index==count-1).
- On tag arrival, {mem_rd_data, last} is written into the FIFO. Overflow is impossible by the credit rule; overflow is an assertion failure.
- FIFO is first-word-fall-through: triangle_tf_m_valid = !fifo_empty.
  - triangle_tf_m_data = {fifo_head.triangle, latched transform}.
  - metadata.triangle_last = head.last.
  - metadata.model_last = head.last && latched model_last.
- Pop on valid&&ready. Data/metadata are stable while valid&&!ready.
- Latency: accept at edge N gives mem_rd_en in cycle N+1 and first valid in cycle N+2+MEM_LAT.
- Throughput: 1 beat/cycle with ready held high (given FIFO_DEPTH>=MEM_LAT+1). Transform itself accepts 1 per 8 cycles; backpressure stalls issue via the credit rule only.
- Simultaneous FIFO push and pop in one cycle: occupancy unchanged, credit freed the same cycle.
- Reset mid-operation: rst flushes the FIFO, clears the tag pipeline and counters, and returns to IDLE. RAM data returning after reset is ignored because its tag was cleared. No partial beat is presented after reset.
- cmd_s_* inputs are ignored outside IDLE.

Test Plan:
- MEM_LAT=2, FIFO_DEPTH=4, cmd base=0x010, count=3, model_last=1, ready held 1 -> reads at 0x010,0x011,0x012 in consecutive cycles. First valid 4 cycles after accept, then 3 consecutive beats. triangle_last/model_last are 0,0 / 0,0 / 1,1. busy drops after the third beat.
- Same command with ready toggling 1 cycle on, 3 off -> never more than 4 reads outstanding+buffered. Beats arrive in address order, data stable while stalled, no loss or duplication.
- base=0xFFE, count=4 -> addresses 0xFFE,0xFFF,0x000,0x001. Last flag only on 0x001.
- count=0, model_last=1 -> err_empty_cmd pulses once, no mem_rd_en, no output beat, cmd_s_ready stays 1.
- Two back-to-back commands (A count=2 model_last=0, B count=1 model_last=1) presented with valid held -> B is accepted only after A's last beat. Output shows A: last flags 0,1 with model_last 0; B: triangle_last=1, model_last=1. Transform fields switch exactly at the boundary.
- Assert rst one cycle after the second read of a count=5 command -> next cycle valid=0, busy=0, cmd_s_ready=1. RAM data for in-flight reads produces no beats. A new count=1 command then completes normally.
